// File: rtl/e3_mult9_serial_ctrl.sv
// Serial x9 multiplier for excess-3 numbers: consumes digits LSD first, emits
// the product LSD first, and appends the final carry digit flagged out_last.
module e3_mult9_serial_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_digit,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_digit,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t           r_state;
    logic [3:0]       r_carry;
    logic [IDX_W-1:0] r_count;
    logic             r_first;
    logic [3:0]       r_out_digit;
    logic             r_out_last;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_valid;
    logic             r_err;

    logic       w_code_ok;
    logic [3:0] w_d;
    logic [6:0] w_p;
    logic [3:0] w_units;
    logic [3:0] w_tens;
    logic       w_slot_free;
    logic       w_accept;

    // Out-of-range codes still advance the frame, contributing a zero digit.
    assign w_code_ok   = (in_digit >= 4'd3) && (in_digit <= 4'd12);
    assign w_d         = w_code_ok ? (in_digit - 4'd3) : 4'd0;
    assign w_p         = 7'(w_d) * 7'd9 + 7'(r_carry);
    assign w_units     = 4'(w_p % 7'd10);
    assign w_tens      = 4'(w_p / 7'd10);

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = !rst && (r_state == S_RUN) && w_slot_free;
    assign w_accept    = in_valid && in_ready;

    assign out_digit   = r_out_digit;
    assign out_last    = r_out_last;
    assign out_idx     = r_out_idx;
    assign out_valid   = r_out_valid;
    assign err         = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_carry     <= 4'd0;
            r_count     <= '0;
            r_first     <= 1'b1;
            r_out_digit <= 4'b0011;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_out_digit <= w_units + 4'd3;
                        r_out_last  <= 1'b0;
                        r_out_idx   <= r_count;
                        r_out_valid <= 1'b1;
                        r_carry     <= w_tens;
                        r_count     <= r_count + 1'b1;
                        r_first     <= 1'b0;
                        // First digit of a frame restarts the sticky error.
                        r_err       <= r_first ? !w_code_ok : (r_err || !w_code_ok);
                        if (in_last)
                            r_state <= S_FLUSH;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (w_slot_free) begin
                        r_out_digit <= r_carry + 4'd3;
                        r_out_last  <= 1'b1;
                        r_out_idx   <= r_count;
                        r_out_valid <= 1'b1;
                        r_carry     <= 4'd0;
                        r_count     <= '0;
                        r_first     <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_e3_mult9_serial_ctrl.sv
// Bench for e3_mult9_serial_ctrl: arithmetic reference model plus literal
// product streams for the hand-worked frames.
module tb_e3_mult9_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_digit;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_digit;
    logic       out_last;
    logic [3:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    e3_mult9_serial_ctrl #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_digit(in_digit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_digit(out_digit), .out_last(out_last), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // Reference: product digit k is digit k of 9 * (value of input digits 0..k).
    longint     pow10 [0:19];
    longint     mV;
    int         mk;
    logic       merr;
    logic [8:0] q[$];
    logic [8:0] got[$];
    logic       prev_hold;
    logic [8:0] prev_out;

    initial begin
        pow10[0] = 1;
        for (int i = 1; i < 20; i++) pow10[i] = pow10[i-1] * 10;
        mV = 0; mk = 0; merr = 1'b0; prev_hold = 1'b0; prev_out = '0;
    end

    always @(negedge clk) begin
        logic [8:0] e;
        logic       inv;
        longint     dv;
        if (rst) begin
            q.delete();
            mV = 0; mk = 0; merr = 1'b0; prev_hold = 1'b0;
            chk("in_ready_in_reset", in_ready, 1'b0);
        end else begin
            chk("err", err, merr);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", {out_last, out_idx, out_digit}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("out_digit", out_digit, e[3:0]);
                    chk("out_idx", out_idx, e[7:4]);
                    chk("out_last", out_last, e[8]);
                end
                got.push_back({out_last, out_idx, out_digit});
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {out_last, out_idx, out_digit};
            if (in_valid && in_ready) begin
                inv  = (in_digit < 4'd3) || (in_digit > 4'd12);
                dv   = inv ? 0 : longint'(in_digit) - 3;
                merr = (mk == 0) ? inv : (merr | inv);
                mV   = mV + dv * pow10[mk];
                q.push_back({1'b0, 4'(mk % 16), 4'((9 * mV / pow10[mk]) % 10 + 3)});
                if (in_last) begin
                    q.push_back({1'b1, 4'((mk + 1) % 16), 4'(9 * mV / pow10[mk+1] + 3)});
                    mV = 0;
                    mk = 0;
                end else begin
                    mk++;
                end
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic l);
        int t = 0;
        in_digit = d; in_last = l; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 1'b1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) chk("drain_timeout", 1'b1, 1'b0);
    endtask

    task automatic check_got(input string nm, input logic [8:0] exp[$]);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(nm, got[i], exp[i]);
        got.delete();
    endtask

    task automatic check_reset_vals(input string nm);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1'b0);
        chk({nm, "_digit"}, out_digit, 4'b0011);
        chk({nm, "_last"}, out_last, 1'b0);
        chk({nm, "_idx"}, out_idx, 4'd0);
        chk({nm, "_err"}, err, 1'b0);
        chk({nm, "_in_ready"}, in_ready, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_digit = 4'd0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // 0 x 9 = 00
        got.delete();
        send(4'b0011, 1'b1);
        drain();
        check_got("f0", '{9'h003, 9'h113});

        // 12 x 9 = 108
        send(4'b0101, 1'b0);
        send(4'b0100, 1'b1);
        drain();
        check_got("f12", '{9'h00B, 9'h013, 9'h124});

        // 99 x 9 = 891
        send(4'b1100, 1'b0);
        send(4'b1100, 1'b1);
        drain();
        check_got("f99", '{9'h004, 9'h01C, 9'h12B});

        // Backpressure on 12: slot holds 1011 and no further digit is taken
        send(4'b0101, 1'b0);
        out_ready = 1'b0;
        in_digit = 4'b0100; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_digit", out_digit, 4'b1011);
            chk("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(4'b0100, 1'b1);
        drain();
        check_got("bp12", '{9'h00B, 9'h013, 9'h124});

        // Invalid code treated as 0: digits 0,1 -> 090, err raised at accept
        send(4'b1111, 1'b0);
        @(negedge clk);
        chk("err_set", err, 1'b1);
        @(posedge clk); #1;
        send(4'b0100, 1'b1);
        drain();
        chk("err_sticky", err, 1'b1);
        check_got("finv", '{9'h003, 9'h01C, 9'h123});
        send(4'b0100, 1'b1);
        @(negedge clk);
        chk("err_cleared", err, 1'b0);
        @(posedge clk); #1;
        drain();
        got.delete();

        // Long frame: out_idx wraps after 15, carry digit lands on idx 1
        for (int i = 0; i < 17; i++) send(4'b1100, (i == 16));
        drain();
        chk("wrap_len", got.size(), 18);
        if (got.size() == 18) begin
            chk("wrap_first", got[0], 9'h004);
            chk("wrap_idx15", got[15], 9'h0FC);
            chk("wrap_idx0", got[16], 9'h00C);
            chk("wrap_final", got[17], 9'h11B);
        end
        got.delete();

        // Reset after 2 of 4 digits, then 5 x 9 = 45 from a clean state
        send(4'b0111, 1'b0);
        send(4'b1010, 1'b0);
        rst = 1'b1;
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        got.delete();
        send(4'b1000, 1'b1);
        drain();
        check_got("f5", '{9'h008, 9'h117});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
